touch_brush_painter: RTL and testbench

- Write-side stage that sits directly upstream of the shared VRAM frame buffer.
- Consumes touch samples from the FT6206 controller and converts display coordinates (240x320) to frame-buffer coordinates (120x160, column-ordered).
- Stamps a square brush of the current draw colour into VRAM through the VRAM write port.
- Also owns the full-buffer clear, run at reset and on request, so no other logic drives the VRAM write port.

---
 rtl/touch_brush_painter_if.sv | 27 ++
 rtl/touch_brush_painter.sv | 156 +++++++++++++++
 tb/tb_touch_brush_painter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/touch_brush_painter_if.sv
// Touch-sample input and VRAM write-port bundle for the brush painter.
// The slave side is the painter; the master side is its environment.
interface touch_brush_painter_if #(
  parameter int unsigned VRAM_W = 8,
  parameter int unsigned ADDR_W = 15
);
  logic              touch_valid;
  logic [8:0]        touch_x;
  logic [8:0]        touch_y;
  logic [VRAM_W-1:0] draw_color;
  logic              clear_req;
  logic              vram_wr_ena;
  logic [ADDR_W-1:0] vram_wr_addr;
  logic [VRAM_W-1:0] vram_wr_data;
  logic              busy;
  logic              clearing;

  modport master (
    output touch_valid, touch_x, touch_y, draw_color, clear_req,
    input  vram_wr_ena, vram_wr_addr, vram_wr_data, busy, clearing
  );

  modport slave (
    input  touch_valid, touch_x, touch_y, draw_color, clear_req,
    output vram_wr_ena, vram_wr_addr, vram_wr_data, busy, clearing
  );
endinterface

// File: rtl/touch_brush_painter.sv
// Converts touch samples to frame-buffer stamps of a square brush and owns
// the full-buffer clear; sole driver of the VRAM write port.
module touch_brush_painter #(
  parameter int unsigned       DISPLAY_WIDTH  = 240,
  parameter int unsigned       DISPLAY_HEIGHT = 320,
  parameter int unsigned       VRAM_W         = 8,
  parameter int unsigned       BRUSH_R        = 1,
  parameter logic [VRAM_W-1:0] CLEAR_COLOR    = 8'hFF
) (
  input logic                  clk,
  input logic                  rst,
  touch_brush_painter_if.slave bus
);
  localparam int unsigned BUF_W  = DISPLAY_WIDTH / 2;
  localparam int unsigned BUF_H  = DISPLAY_HEIGHT / 2;
  localparam int unsigned VRAM_L = BUF_W * BUF_H;
  localparam int unsigned ADDR_W = $clog2(VRAM_L);
  localparam int unsigned BX_W   = $clog2(BUF_W);
  localparam int unsigned BY_W   = $clog2(BUF_H);
  localparam int unsigned CX_W   = BX_W + 1;
  localparam int unsigned CY_W   = BY_W + 1;
  localparam int unsigned OFF_W  = $clog2(BRUSH_R + 1) + 1;

  localparam logic signed [OFF_W-1:0] OFF_MAX = OFF_W'(BRUSH_R);
  localparam logic signed [OFF_W-1:0] OFF_MIN = -OFF_MAX;
  localparam logic signed [OFF_W-1:0] OFF_ONE = OFF_W'(1);
  localparam logic signed [CX_W-1:0]  CX_LIM  = CX_W'(BUF_W);
  localparam logic signed [CY_W-1:0]  CY_LIM  = CY_W'(BUF_H);
  localparam logic [ADDR_W-1:0]       CLR_END = ADDR_W'(VRAM_L - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_PAINT} state_t;

  state_t                   state;
  logic [ADDR_W-1:0]        clr_cnt;
  logic [BX_W-1:0]          bx;
  logic [BY_W-1:0]          by;
  logic [VRAM_W-1:0]        color;
  logic signed [OFF_W-1:0]  off_x;
  logic signed [OFF_W-1:0]  off_y;
  logic [BX_W-1:0]          last_bx;
  logic [BY_W-1:0]          last_by;
  logic [VRAM_W-1:0]        last_color;
  logic                     last_valid;

  logic [BX_W-1:0]          t_bx;
  logic [BY_W-1:0]          t_by;
  logic                     t_ok;
  logic                     t_dup;
  logic signed [CX_W-1:0]   cx;
  logic signed [CY_W-1:0]   cy;
  logic                     in_buf;
  logic [ADDR_W-1:0]        stamp_addr;

  // Incoming sample mapped to buffer coordinates and filtered
  always_comb begin
    t_bx  = BX_W'(bus.touch_x >> 1);
    t_by  = BY_W'(bus.touch_y >> 1);
    t_ok  = bus.touch_valid
            && (bus.touch_x < 9'(DISPLAY_WIDTH))
            && (bus.touch_y < 9'(DISPLAY_HEIGHT));
    t_dup = last_valid && (t_bx == last_bx) && (t_by == last_by)
            && (bus.draw_color == last_color);
  end

  // Current brush cell; one extra sign bit keeps edge offsets from wrapping
  always_comb begin
    cx = $signed({1'b0, bx}) + $signed({{(CX_W-OFF_W){off_x[OFF_W-1]}}, off_x});
    cy = $signed({1'b0, by}) + $signed({{(CY_W-OFF_W){off_y[OFF_W-1]}}, off_y});
    in_buf = !cx[CX_W-1] && !cy[CY_W-1] && (cx < CX_LIM) && (cy < CY_LIM);
    stamp_addr = ADDR_W'(cy[BY_W-1:0]) + ADDR_W'(cx[BX_W-1:0]) * ADDR_W'(BUF_H);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_CLEAR;
      clr_cnt          <= '0;
      bx               <= '0;
      by               <= '0;
      color            <= '0;
      off_x            <= '0;
      off_y            <= '0;
      last_bx          <= '0;
      last_by          <= '0;
      last_color       <= '0;
      last_valid       <= 1'b0;
      bus.vram_wr_ena  <= 1'b0;
      bus.vram_wr_addr <= '0;
      bus.vram_wr_data <= '0;
      bus.busy         <= 1'b1;
      bus.clearing     <= 1'b1;
    end else begin
      bus.vram_wr_ena <= 1'b0;
      if (bus.clear_req) begin
        // Clear wins everywhere; an interrupted stamp is simply forgotten
        state            <= S_CLEAR;
        clr_cnt          <= '0;
        bus.vram_wr_addr <= '0;
        bus.vram_wr_data <= '0;
        bus.busy         <= 1'b1;
        bus.clearing     <= 1'b1;
      end else begin
        case (state)
          S_CLEAR: begin
            bus.vram_wr_ena  <= 1'b1;
            bus.vram_wr_addr <= clr_cnt;
            bus.vram_wr_data <= CLEAR_COLOR;
            if (clr_cnt == CLR_END) begin
              state        <= S_IDLE;
              last_valid   <= 1'b0;
              bus.busy     <= 1'b0;
              bus.clearing <= 1'b0;
            end else begin
              clr_cnt <= clr_cnt + ADDR_W'(1);
            end
          end
          S_IDLE: begin
            if (t_ok && !t_dup) begin
              bx       <= t_bx;
              by       <= t_by;
              color    <= bus.draw_color;
              off_x    <= OFF_MIN;
              off_y    <= OFF_MIN;
              state    <= S_PAINT;
              bus.busy <= 1'b1;
            end
          end
          S_PAINT: begin
            bus.vram_wr_ena  <= in_buf;
            bus.vram_wr_addr <= stamp_addr;
            bus.vram_wr_data <= color;
            if (off_y == OFF_MAX) begin
              off_y <= OFF_MIN;
              if (off_x == OFF_MAX) begin
                state      <= S_IDLE;
                bus.busy   <= 1'b0;
                last_bx    <= bx;
                last_by    <= by;
                last_color <= color;
                last_valid <= 1'b1;
              end else begin
                off_x <= off_x + OFF_ONE;
              end
            end else begin
              off_y <= off_y + OFF_ONE;
            end
          end
          default: begin
            state        <= S_IDLE;
            bus.busy     <= 1'b0;
            bus.clearing <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_touch_brush_painter.sv
// Scoreboard bench for touch_brush_painter: expected VRAM writes are queued
// as stimulus is applied and retired in order as the write port fires.
module tb_touch_brush_painter;
  localparam int unsigned VRAM_L = 19200;

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  wr_t  q[$];

  // model of the last-painted stamp
  int          m_bx = 0;
  int          m_by = 0;
  logic [7:0]  m_col = 8'h00;
  bit          m_valid = 1'b0;

  touch_brush_painter_if bus ();

  touch_brush_painter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_clear();
    wr_t w;
    for (int a = 0; a < int'(VRAM_L); a++) begin
      w.addr = 15'(a);
      w.data = 8'hFF;
      q.push_back(w);
    end
  endtask

  // Retire expected writes in order
  always @(negedge clk) begin
    if (rst && bus.vram_wr_ena) begin
      if (q.size() == 0) begin
        check("unexpected_wr", 32'(bus.vram_wr_ena), 32'd0);
      end else begin
        wr_t e;
        e = q.pop_front();
        check("wr_addr", 32'(bus.vram_wr_addr), 32'(e.addr));
        check("wr_data", 32'(bus.vram_wr_data), 32'(e.data));
      end
    end
  end

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (!bus.busy && q.size() == 0) break;
    end
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_clearing", 32'(bus.clearing), 32'd0);
    check("idle_sb_empty", 32'(q.size()), 32'd0);
    tick();
    check("idle_wr_ena", 32'(bus.vram_wr_ena), 32'd0);
  endtask

  // Push the model's stamp; returns whether the first offset is in-buffer
  task automatic push_stamp(input int bx, input int by, input logic [7:0] col,
                            input int n_offs, output bit first_in);
    wr_t w;
    int  k;
    k = 0;
    first_in = 1'b0;
    for (int dx = -1; dx <= 1; dx++) begin
      for (int dy = -1; dy <= 1; dy++) begin
        if (k < n_offs && bx + dx >= 0 && bx + dx < 120 && by + dy >= 0 && by + dy < 160) begin
          w.addr = 15'((by + dy) + (bx + dx) * 160);
          w.data = col;
          q.push_back(w);
          if (k == 0) first_in = 1'b1;
        end
        k++;
      end
    end
  endtask

  task automatic touch(input int x, input int y, input logic [7:0] col);
    int bx;
    int by;
    int n;
    bit acc;
    bit first_in;
    bx = x / 2;
    by = y / 2;
    first_in = 1'b0;
    acc = (x < 240) && (y < 320) && !(m_valid && bx == m_bx && by == m_by && col == m_col);
    if (acc) begin
      push_stamp(bx, by, col, 9, first_in);
      m_bx = bx;
      m_by = by;
      m_col = col;
      m_valid = 1'b1;
    end
    bus.touch_valid = 1'b1;
    bus.touch_x = 9'(x);
    bus.touch_y = 9'(y);
    bus.draw_color = col;
    tick();
    bus.touch_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (acc && i == 0) check("latch_cycle_wr_ena", 32'(bus.vram_wr_ena), 32'd0);
      if (acc && i == 1) check("first_wr_latency", 32'(bus.vram_wr_ena), 32'(first_in));
      if (!bus.busy) break;
      n++;
    end
    check("paint_cycles", 32'(n), acc ? 32'd9 : 32'd0);
    check("paint_sb_empty", 32'(q.size()), 32'd0);
    tick();
  endtask

  initial begin
    bit dummy;
    bus.touch_valid = 1'b0;
    bus.touch_x = '0;
    bus.touch_y = '0;
    bus.draw_color = '0;
    bus.clear_req = 1'b0;

    repeat (3) tick();
    check("rst_wr_ena", 32'(bus.vram_wr_ena), 32'd0);
    check("rst_wr_addr", 32'(bus.vram_wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.vram_wr_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_clearing", 32'(bus.clearing), 32'd1);

    push_clear();
    rst = 1'b1;
    wait_idle(VRAM_L + 100);

    touch(100, 50, 8'h00);
    touch(0, 0, 8'h00);
    touch(240, 10, 8'h00);
    touch(10, 320, 8'h00);
    touch(100, 50, 8'h00);
    touch(100, 50, 8'h00);
    touch(100, 50, 8'h1C);
    touch(239, 319, 8'h33);

    // clear_req on the 4th paint cycle; three writes precede the abort
    push_stamp(100, 150, 8'h55, 3, dummy);
    push_clear();
    bus.touch_valid = 1'b1;
    bus.touch_x = 9'd200;
    bus.touch_y = 9'd300;
    bus.draw_color = 8'h55;
    tick();
    bus.touch_valid = 1'b0;
    repeat (3) tick();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    m_valid = 1'b0;
    check("abort_clearing", 32'(bus.clearing), 32'd1);
    check("abort_addr", 32'(bus.vram_wr_addr), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd1);
    bus.touch_valid = 1'b1;
    bus.touch_x = 9'd100;
    bus.touch_y = 9'd50;
    bus.draw_color = 8'h1C;
    repeat (100) tick();
    bus.touch_valid = 1'b0;
    wait_idle(VRAM_L + 100);
    touch(200, 300, 8'h55);

    // asynchronous reset in the middle of a clear
    push_clear();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    repeat (500) tick();
    rst = 1'b0;
    #1;
    check("midrst_wr_ena", 32'(bus.vram_wr_ena), 32'd0);
    check("midrst_wr_addr", 32'(bus.vram_wr_addr), 32'd0);
    check("midrst_wr_data", 32'(bus.vram_wr_data), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd1);
    check("midrst_clearing", 32'(bus.clearing), 32'd1);
    q.delete();
    push_clear();
    m_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    wait_idle(VRAM_L + 100);
    touch(100, 50, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
